// File: rtl/player_pkg.sv
// Shared types and constants for the player sprite: jump states, keycodes and motion limits.
// Used by the motion controller, the ball datapath and the renderer.
package player_pkg;

  typedef enum logic [1:0] {
    GROUND  = 2'd0,
    ASCEND  = 2'd1,
    DESCEND = 2'd2,
    LAND    = 2'd3
  } jump_state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_A = 8'h04;

  localparam logic [9:0] GROUND_Y       = 10'd378;
  localparam logic [9:0] APEX_Y         = 10'd300;
  localparam logic [9:0] JUMP_STEP      = 10'd3;
  localparam logic [9:0] X_STEP         = 10'd1;
  localparam logic [9:0] X_MIN          = 10'd10;
  localparam logic [9:0] X_MAX          = 10'd689;
  localparam logic [9:0] SCROLL_START_X = 10'd320;
  localparam logic [5:0] SCROLL_MAX     = 6'd60;

  // 10-bit two's-complement negation for motion deltas.
  function automatic logic [9:0] neg10(input logic [9:0] v);
    return ~v + 10'd1;
  endfunction

  // A key counts as pressed when it appears in either USB slot.
  function automatic logic key_in(input logic [7:0] slot0, input logic [7:0] slot1,
                                  input logic [7:0] key);
    return (slot0 == key) || (slot1 == key);
  endfunction

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Bundle between the player motion controller and the position datapath / keyboard.
// No valid/ready pair: every frame_clk edge is a transfer; outputs are valid right after it.
interface player_motion_ctrl_if;

  logic [7:0] keycode;
  logic [7:0] keycode1;
  logic [9:0] PlayerX;
  logic [9:0] PlayerY;
  logic [9:0] MotionX;
  logic [9:0] MotionY;
  logic       Y_Load;
  logic [5:0] ScrollX;
  logic       Airborne;

  modport master (
    output keycode, keycode1, PlayerX, PlayerY,
    input  MotionX, MotionY, Y_Load, ScrollX, Airborne
  );

  modport slave (
    input  keycode, keycode1, PlayerX, PlayerY,
    output MotionX, MotionY, Y_Load, ScrollX, Airborne
  );

endinterface

// File: rtl/player_key_decode.sv
// Decodes both keycode slots into walk directions, W level and a one-shot jump press.
// jump_armed stops a held W from re-triggering a jump.
module player_key_decode
  import player_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode1,
  output logic       jump_press,
  output logic       w_held,
  output logic       left,
  output logic       right
);

  logic jump_armed;

  assign w_held     = key_in(keycode, keycode1, KEY_W);
  assign left       = key_in(keycode, keycode1, KEY_A);
  assign right      = key_in(keycode, keycode1, KEY_D);
  assign jump_press = w_held & jump_armed;

  // Re-arms on the first frame W is absent from both slots.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      jump_armed <= 1'b1;
    end else if (!w_held) begin
      jump_armed <= 1'b1;
    end else if (jump_press) begin
      jump_armed <= 1'b0;
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame player motion controller: jump FSM on Y, walk/scroll rule on X, scroll offset.
// All outputs are registered and consumed by the datapath on the following frame_clk.
module player_motion_ctrl
  import player_pkg::*;
(
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  player_motion_ctrl_if.slave  bus,
  output jump_state_t          state_dbg
);

  logic jump_press;
  logic w_held;
  logic left;
  logic right;

  player_key_decode u_key_decode (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .keycode    (bus.keycode),
    .keycode1   (bus.keycode1),
    .jump_press (jump_press),
    .w_held     (w_held),
    .left       (left),
    .right      (right)
  );

  jump_state_t state;
  jump_state_t state_next;

  logic [9:0]  motion_x_q;
  logic [9:0]  motion_y_q;
  logic        y_load_q;
  logic [5:0]  scroll_q;
  logic        airborne_q;

  logic [9:0]  motion_x_next;
  logic [9:0]  motion_y_next;
  logic        y_load_next;
  logic [5:0]  scroll_next;
  logic        airborne_next;

  logic [10:0] y_plus_step;
  assign y_plus_step = {1'b0, bus.PlayerY} + {1'b0, JUMP_STEP};

  // Y axis: next state first, then the registered outputs follow the new state.
  always_comb begin
    state_next = state;
    case (state)
      GROUND: begin
        if (jump_press) state_next = ASCEND;
      end
      ASCEND: begin
        if ((bus.PlayerY <= (APEX_Y + JUMP_STEP)) || !w_held) state_next = DESCEND;
      end
      DESCEND: begin
        if (y_plus_step >= {1'b0, GROUND_Y}) state_next = LAND;
      end
      LAND: begin
        state_next = GROUND;
      end
      default: begin
        state_next = GROUND;
      end
    endcase
  end

  always_comb begin
    motion_y_next = 10'd0;
    y_load_next   = 1'b0;
    airborne_next = 1'b0;
    case (state_next)
      ASCEND: begin
        motion_y_next = neg10(JUMP_STEP);
        airborne_next = 1'b1;
      end
      DESCEND: begin
        motion_y_next = JUMP_STEP;
        airborne_next = 1'b1;
      end
      LAND: begin
        y_load_next   = 1'b1;
        airborne_next = 1'b1;
      end
      default: begin
        motion_y_next = 10'd0;
      end
    endcase
  end

  // X axis: walking right past SCROLL_START_X scrolls the world until it saturates.
  always_comb begin
    motion_x_next = 10'd0;
    scroll_next   = scroll_q;
    if (left && !right) begin
      if (bus.PlayerX > X_MIN) motion_x_next = neg10(X_STEP);
    end else if (right && !left) begin
      if ((bus.PlayerX >= SCROLL_START_X) && (scroll_q < SCROLL_MAX)) begin
        scroll_next = scroll_q + 6'd1;
      end else if (bus.PlayerX < X_MAX) begin
        motion_x_next = X_STEP;
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= GROUND;
      motion_x_q <= 10'd0;
      motion_y_q <= 10'd0;
      y_load_q   <= 1'b0;
      scroll_q   <= 6'd0;
      airborne_q <= 1'b0;
    end else begin
      state      <= state_next;
      motion_x_q <= motion_x_next;
      motion_y_q <= motion_y_next;
      y_load_q   <= y_load_next;
      scroll_q   <= scroll_next;
      airborne_q <= airborne_next;
    end
  end

  assign bus.MotionX  = motion_x_q;
  assign bus.MotionY  = motion_y_q;
  assign bus.Y_Load   = y_load_q;
  assign bus.ScrollX  = scroll_q;
  assign bus.Airborne = airborne_q;
  assign state_dbg    = state;

endmodule
